flag_branch_unit: RTL

Holds the architectural N/V/Z flag register written by the 16-bit ALU in EX, and resolves conditional branches in ID against it. It applies the per-opcode flag-update mask and detects the hazard where a branch in ID depends on a flag write still in EX. It then stalls ID for one cycle, or bypasses when configured. It also keeps a saturating count of flag-hazard stall cycles for performance debug.

---
 rtl/flag_branch_unit_if.sv | 27 ++
 rtl/flag_branch_unit.sv | 103 ++++++++++
 2 files changed

// File: rtl/flag_branch_unit_if.sv
// EX flag-write / ID branch-resolve bundle for flag_branch_unit.
// master = pipeline side driving EX/ID requests, slave = flag_branch_unit.
interface flag_branch_unit_if #(
  parameter int CNT_W = 16
);
  logic             ex_valid;
  logic             ex_hold;
  logic [3:0]       ex_opcode;
  logic [2:0]       ex_flags;
  logic             flush;
  logic             br_valid;
  logic [2:0]       br_cond;
  logic             br_taken;
  logic             br_stall;
  logic [2:0]       flag_q;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output ex_valid, ex_hold, ex_opcode, ex_flags, flush, br_valid, br_cond,
    input  br_taken, br_stall, flag_q, stall_cnt
  );

  modport slave (
    input  ex_valid, ex_hold, ex_opcode, ex_flags, flush, br_valid, br_cond,
    output br_taken, br_stall, flag_q, stall_cnt
  );
endinterface

// File: rtl/flag_branch_unit.sv
// N/V/Z flag register written from EX, conditional branch resolution in ID with
// flag-hazard stall and saturating stall counter. Define FLAG_BYPASS_EN to bypass instead of stall.
module flag_branch_unit #(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  flag_branch_unit_if.slave bus
);

  typedef enum logic {
    ST_RUN,
    ST_HOLD
  } state_t;

  state_t           r_state;
  logic [2:0]       r_flags;
  logic [CNT_W-1:0] r_stall_cnt;

  logic       w_we;
  logic [2:0] w_mask;
  logic [2:0] w_seen;
  logic       w_cond_true;
  logic       w_stall;
  logic       w_taken;

  // Flag bits are {N,V,Z}
  always_comb begin
    w_mask = 3'b000;
    case (bus.ex_opcode)
      4'h0, 4'h1:             w_mask = 3'b111;
      4'h2, 4'h4, 4'h5, 4'h6: w_mask = 3'b001;
      default:                w_mask = 3'b000;
    endcase
  end

  assign w_we = bus.ex_valid & ~bus.ex_hold & ~bus.flush;

`ifdef FLAG_BYPASS_EN
  assign w_seen  = w_we ? ((bus.ex_flags & w_mask) | (r_flags & ~w_mask)) : r_flags;
  assign w_stall = 1'b0;
`else
  logic w_hazard;
  assign w_hazard = bus.br_valid & ~bus.flush & w_we & (w_mask != 3'b000) &
                    (bus.br_cond != 3'b111);
  assign w_seen   = r_flags;
  // Reset is folded in so an asserted rst_n drops the stall without waiting for a clock
  assign w_stall  = w_hazard & rst_n;
`endif

  always_comb begin
    w_cond_true = 1'b0;
    case (bus.br_cond)
      3'b000:  w_cond_true = ~w_seen[0];
      3'b001:  w_cond_true = w_seen[0];
      3'b010:  w_cond_true = ~w_seen[0] & ~w_seen[2];
      3'b011:  w_cond_true = w_seen[2];
      3'b100:  w_cond_true = w_seen[0] | (~w_seen[0] & ~w_seen[2]);
      3'b101:  w_cond_true = w_seen[2] | w_seen[0];
      3'b110:  w_cond_true = w_seen[1];
      default: w_cond_true = 1'b1;
    endcase
  end

  assign w_taken = rst_n & bus.br_valid & ~bus.flush & ~w_stall & w_cond_true;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags <= '0;
    end else if (w_we) begin
      r_flags <= (r_flags & ~w_mask) | (bus.ex_flags & w_mask);
    end
  end

  // HOLD re-stalls only if a fresh hazard shows up; both states leave on flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
    end else if (bus.flush) begin
      r_state <= ST_RUN;
    end else begin
      case (r_state)
        ST_RUN:  r_state <= w_stall ? ST_HOLD : ST_RUN;
        ST_HOLD: r_state <= w_stall ? ST_HOLD : ST_RUN;
        default: r_state <= ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign bus.br_stall  = w_stall;
  assign bus.br_taken  = w_taken;
  assign bus.flag_q    = r_flags;
  assign bus.stall_cnt = r_stall_cnt;

endmodule
